// File: rtl/nios2_dbg_scan_master_if.sv
// Request/response handshake plus the virtual-JTAG pin set of the Nios II
// debug slave, bundled so the scan master and its user connect with one port.
//
// Handshake rules (both channels): a transfer happens on the rising clk edge
// where valid && ready are both 1. The request side drives req_valid/req_ir/
// req_dr and the block raises req_ready only when idle. The block holds
// rsp_valid and rsp_dr/rsp_ir_out stable until the edge where rsp_ready is 1.
interface nios2_dbg_scan_master_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [IR_WIDTH-1:0] req_ir;
  logic [DR_WIDTH-1:0] req_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [IR_WIDTH-1:0] vji_ir_in;
  logic [IR_WIDTH-1:0] vji_ir_out;
  logic                vji_rti;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;

  // Scan master side.
  modport master (
    input  req_valid, req_ir, req_dr, rsp_ready, vji_tdo, vji_ir_out,
    output req_ready, rsp_valid, rsp_dr, rsp_ir_out,
           vji_tck, vji_tdi, vji_ir_in, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
  );

  // Requester / debug slave side.
  modport slave (
    output req_valid, req_ir, req_dr, rsp_ready, vji_tdo, vji_ir_out,
    input  req_ready, rsp_valid, rsp_dr, rsp_ir_out,
           vji_tck, vji_tdi, vji_ir_in, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
  );
endinterface

// File: rtl/nios2_dbg_scan_master.sv
// System-clock scan initiator for the Nios II virtual-JTAG debug slave.
// One accepted request runs UIR -> CDR -> SDR (DR_WIDTH periods) -> UDR and
// returns the shifted-out DR. tck is divided from clk; every strobe and tdi
// change happens at the phase wrap, which is the tck falling point.
module nios2_dbg_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  nios2_dbg_scan_master_if.master bus,
  output logic [2:0]              dbg_state_o
);

  localparam int PH_MAX = 2 * TCK_DIV - 1;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BC_W   = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

  // START is a one-cycle gap after accept so the phase counter begins at 0
  // together with the UIR strobe.
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_UIR, S_CDR, S_SDR, S_UDR, S_RSP
  } state_e;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [BC_W-1:0]     bc_q, bc_d;
  logic [DR_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d, ir_out_q, ir_out_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic tck_q, tck_d, tdi_q, tdi_d, rti_q, rti_d;
  logic uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d;
  logic active, wrap, rise;

  // Next-state, phase/bit counters, shift registers and registered pin values.
  always_comb begin
    state_d     = state_q;
    ph_d        = '0;
    bc_d        = bc_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_dr_d    = rsp_dr_q;
    ir_in_d     = ir_in_q;
    ir_out_d    = ir_out_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    tdi_d       = tdi_q;
    rti_d       = rti_q;
    uir_d       = uir_q;
    cdr_d       = cdr_q;
    sdr_d       = sdr_q;
    udr_d       = udr_q;
    active = (state_q == S_UIR) || (state_q == S_CDR) ||
             (state_q == S_SDR) || (state_q == S_UDR);
    wrap   = active && (ph_q == PH_W'(PH_MAX));
    // Phase about to reach TCK_DIV: the edge where tck rises, slave outputs
    // are still the values from before its own tck edge.
    rise   = active && (ph_q == PH_W'(TCK_DIV - 1));
    if (active) ph_d = wrap ? '0 : ph_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        rti_d       = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          state_d     = S_START;
          ir_in_d     = bus.req_ir;
          tx_d        = bus.req_dr;
          req_ready_d = 1'b0;
          rti_d       = 1'b0;
        end
      end
      S_START: begin
        state_d = S_UIR;
        uir_d   = 1'b1;
      end
      S_UIR: begin
        if (rise) ir_out_d = bus.vji_ir_out;
        if (wrap) begin
          state_d = S_CDR;
          uir_d   = 1'b0;
          cdr_d   = 1'b1;
        end
      end
      S_CDR: begin
        if (wrap) begin
          state_d = S_SDR;
          cdr_d   = 1'b0;
          sdr_d   = 1'b1;
          bc_d    = BC_W'(DR_WIDTH - 1);
          tdi_d   = tx_q[0];
        end
      end
      S_SDR: begin
        if (rise) rx_d = {bus.vji_tdo, rx_q[DR_WIDTH-1:1]};
        if (wrap) begin
          tx_d = tx_q >> 1;
          if (bc_q == '0) begin
            state_d = S_UDR;
            sdr_d   = 1'b0;
            udr_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            bc_d  = bc_q - 1'b1;
            tdi_d = tx_d[0];
          end
        end
      end
      S_UDR: begin
        if (wrap) begin
          state_d     = S_RSP;
          udr_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dr_d    = rx_q;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          rti_d       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    tck_d = (ph_d >= PH_W'(TCK_DIV));
  end

  // State and output registers; reset abandons any scan in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      bc_q        <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_dr_q    <= '0;
      ir_in_q     <= '0;
      ir_out_q    <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      rti_q       <= 1'b1;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      bc_q        <= bc_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_dr_q    <= rsp_dr_d;
      ir_in_q     <= ir_in_d;
      ir_out_q    <= ir_out_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      tck_q       <= tck_d;
      tdi_q       <= tdi_d;
      rti_q       <= rti_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_dr     = rsp_dr_q;
  assign bus.rsp_ir_out = ir_out_q;
  assign bus.vji_tck    = tck_q;
  assign bus.vji_tdi    = tdi_q;
  assign bus.vji_ir_in  = ir_in_q;
  assign bus.vji_rti    = rti_q;
  assign bus.vji_uir    = uir_q;
  assign bus.vji_cdr    = cdr_q;
  assign bus.vji_sdr    = sdr_q;
  assign bus.vji_udr    = udr_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_nios2_dbg_scan_master.sv
// Bench for nios2_dbg_scan_master: a default-size instance driven against a
// 38-bit debug-slave model and a TCK_DIV=1 / 8-bit instance. Expected data
// comes from the slave model's load value and the request word; latency and
// strobe widths come from the period arithmetic of the scan sequence.
module tb_nios2_dbg_scan_master;
  localparam int DW   = 38;
  localparam int IW   = 2;
  localparam int TD   = 2;
  localparam int DWB  = 8;
  localparam int TDB  = 1;
  localparam int LAT  = 1 + (DW + 3) * 2 * TD;
  localparam int LATB = 1 + (DWB + 3) * 2 * TDB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nios2_dbg_scan_master_if #(.DR_WIDTH(DW),  .IR_WIDTH(IW)) bus ();
  nios2_dbg_scan_master_if #(.DR_WIDTH(DWB), .IR_WIDTH(IW)) bus_b ();
  logic [2:0] dbg_a, dbg_b;

  nios2_dbg_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(TD)) dut_a (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state_o(dbg_a));
  nios2_dbg_scan_master #(.DR_WIDTH(DWB), .IR_WIDTH(IW), .TCK_DIV(TDB)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .dbg_state_o(dbg_b));

  // ---------------- debug slave models ----------------
  logic [DW-1:0] sl_sr, sl_load, sl_udr;
  always @(posedge bus.vji_tck or posedge reset)
    if (reset) sl_sr <= '0;
    else if (bus.vji_cdr) sl_sr <= sl_load;
    else if (bus.vji_sdr) sl_sr <= {bus.vji_tdi, sl_sr[DW-1:1]};
  always @(posedge bus.vji_udr) sl_udr <= sl_sr;
  assign bus.vji_tdo = sl_sr[0];

  logic [DWB-1:0] slb_sr, slb_load, slb_udr;
  always @(posedge bus_b.vji_tck or posedge reset)
    if (reset) slb_sr <= '0;
    else if (bus_b.vji_cdr) slb_sr <= slb_load;
    else if (bus_b.vji_sdr) slb_sr <= {bus_b.vji_tdi, slb_sr[DWB-1:1]};
  always @(posedge bus_b.vji_udr) slb_udr <= slb_sr;
  assign bus_b.vji_tdo = slb_sr[0];

  // ---------------- strobe monitor (instance A) ----------------
  int uir_n = 0, cdr_n = 0, sdr_n = 0, udr_n = 0, rise_n = 0, hyg_err = 0;
  logic [3:0] ord_q[$];
  logic [3:0] prev_s = 4'b0;
  logic       prev_tck = 1'b0;
  always @(negedge clk) begin
    logic [3:0] s;
    s = {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr};
    if ($countones(s) > 1) hyg_err++;
    if (s != prev_s && bus.vji_tck) hyg_err++;
    if (s != prev_s && s != 4'b0) ord_q.push_back(s);
    uir_n += int'(s[3]);
    cdr_n += int'(s[2]);
    sdr_n += int'(s[1]);
    udr_n += int'(s[0]);
    if (bus.vji_tck && !prev_tck && bus.vji_sdr) rise_n++;
    prev_s   = s;
    prev_tck = bus.vji_tck;
  end

  int b_uir, b_cdr, b_sdr, b_udr, b_rise, b_hyg, b_ord;
  task automatic snap_a();
    b_uir = uir_n; b_cdr = cdr_n; b_sdr = sdr_n; b_udr = udr_n;
    b_rise = rise_n; b_hyg = hyg_err; b_ord = ord_q.size();
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_rst_a();
    return 64'({bus.req_ready, bus.rsp_valid, bus.rsp_dr, bus.rsp_ir_out,
                bus.vji_tck, bus.vji_tdi, bus.vji_ir_in,
                bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti});
  endfunction

  function automatic logic [DW-1:0] rand_dr();
    return DW'({$urandom(), $urandom()});
  endfunction

  // ---------------- driver tasks (instance A) ----------------
  task automatic send_a(input logic [IW-1:0] ir, input logic [DW-1:0] dr, output int k);
    bit ok;
    ok = 0;
    k  = 0;
    @(negedge clk);
    bus.req_ir = ir; bus.req_dr = dr; bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.req_ready) ok = 1;
      @(negedge clk);
    end
    k = cyc;
    chk("accept", 64'(ok), 64'd1);
    bus.req_valid = 1'b0;
    bus.req_ir = IW'($urandom());
    bus.req_dr = rand_dr();
    chk("ir_in_latched", 64'(bus.vji_ir_in), 64'(ir));
  endtask

  task automatic finish_a(input int k, input logic [DW-1:0] dr, input logic [DW-1:0] load,
                          input logic [IW-1:0] irout, input bit drain);
    bit seen;
    int lat;
    logic [15:0] ov;
    seen = 0;
    lat  = 0;
    for (int i = 0; i < LAT + 40 && !seen; i++) begin
      if (bus.rsp_valid) begin
        seen = 1;
        lat  = cyc - k;
      end else begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_dr    = rand_dr();
        @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;
    chk("rsp_seen", 64'(seen), 64'd1);
    chk("latency", 64'(lat), 64'(LAT));
    chk("rsp_dr", 64'(bus.rsp_dr), 64'(load));
    chk("rsp_ir_out", 64'(bus.rsp_ir_out), 64'(irout));
    chk("slave_sr_at_udr", 64'(sl_udr), 64'(dr));
    chk("uir_width", 64'(uir_n - b_uir), 64'(2 * TD));
    chk("cdr_width", 64'(cdr_n - b_cdr), 64'(2 * TD));
    chk("sdr_width", 64'(sdr_n - b_sdr), 64'(DW * 2 * TD));
    chk("udr_width", 64'(udr_n - b_udr), 64'(2 * TD));
    chk("sdr_tck_rises", 64'(rise_n - b_rise), 64'(DW));
    chk("strobe_hygiene", 64'(hyg_err - b_hyg), 64'd0);
    ov = '0;
    if (ord_q.size() == b_ord + 4)
      for (int i = 0; i < 4; i++) ov = {ov[11:0], ord_q[b_ord + i]};
    chk("strobe_order", 64'(ov), 64'h8421);
    if (drain) begin
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
      chk("ready_return", 64'(bus.req_ready), 64'd1);
    end
  endtask

  task automatic scan_a(input logic [IW-1:0] ir, input logic [DW-1:0] dr, input logic [DW-1:0] load,
                        input logic [IW-1:0] irout, input bit drain);
    int k;
    snap_a();
    sl_load = load;
    bus.vji_ir_out = irout;
    send_a(ir, dr, k);
    finish_a(k, dr, load, irout, drain);
  endtask

  // ---------------- driver task (instance B) ----------------
  task automatic scan_b(input logic [DWB-1:0] dr, input logic [DWB-1:0] load);
    bit ok, seen;
    int k, lat;
    ok = 0; seen = 0; k = 0; lat = 0;
    slb_load = load;
    @(negedge clk);
    bus_b.req_ir = 2'b01; bus_b.req_dr = dr; bus_b.req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus_b.req_ready) ok = 1;
      @(negedge clk);
    end
    k = cyc;
    bus_b.req_valid = 1'b0;
    bus_b.req_dr = DWB'($urandom());
    chk("b_accept", 64'(ok), 64'd1);
    for (int i = 0; i < LATB + 20 && !seen; i++) begin
      if (bus_b.rsp_valid) begin
        seen = 1;
        lat  = cyc - k;
      end else @(negedge clk);
    end
    chk("b_latency", 64'(lat), 64'(LATB));
    chk("b_rsp_dr", 64'(bus_b.rsp_dr), 64'(load));
    chk("b_rsp_ir_out", 64'(bus_b.rsp_ir_out), 64'(2'b10));
    chk("b_slave_sr_at_udr", 64'(slb_udr), 64'(dr));
    bus_b.rsp_ready = 1'b1;
    @(negedge clk);
    bus_b.rsp_ready = 1'b0;
    chk("b_ready_return", 64'(bus_b.req_ready), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k, v, bpbad;
    bit hit;
    logic [DW-1:0] prev_load, bp_dr, bp_load, ab_dr;

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; bus.req_ir = '0; bus.req_dr = '0;
    bus.vji_ir_out = '0;
    bus_b.req_valid = 1'b0; bus_b.rsp_ready = 1'b0; bus_b.req_ir = '0; bus_b.req_dr = '0;
    bus_b.vji_ir_out = 2'b10;
    sl_load = '0; slb_load = '0;

    // Reset and first ready.
    repeat (3) @(negedge clk);
    chk("reset_values", obs_rst_a(), 64'd1);
    reset = 1'b0;
    #1 chk("ready_before_edge", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_edge", 64'(bus.req_ready), 64'd1);
    chk("rti_idle", 64'(bus.vji_rti), 64'd1);
    chk("tck_idle", 64'(bus.vji_tck), 64'd0);

    // Basic scan against the slave model.
    scan_a(2'b01, 38'h15_A5A5_A5A5, 38'h2A_5A5A_5A5A, 2'b11, 1'b1);

    // Randomized scans.
    for (int n = 0; n < 3; n++)
      scan_a(IW'($urandom()), rand_dr(), rand_dr(), IW'($urandom()), 1'b1);

    // Backpressure: hold response, keep a request pending.
    prev_load = rand_dr();
    scan_a(2'b00, rand_dr(), prev_load, 2'b01, 1'b0);
    snap_a();
    bp_dr   = rand_dr();
    bp_load = rand_dr();
    sl_load = bp_load;
    bus.vji_ir_out = 2'b10;
    bus.req_ir = 2'b10; bus.req_dr = bp_dr; bus.req_valid = 1'b1;
    bpbad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(bus.rsp_valid === 1'b1 && bus.rsp_dr === prev_load && bus.req_ready === 1'b0))
        bpbad++;
    end
    chk("bp_hold", 64'(bpbad), 64'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
    chk("bp_release_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    k = cyc;
    bus.req_valid = 1'b0;
    chk("bp_next_accept", 64'(bus.req_ready), 64'd0);
    chk("bp_rti_low", 64'(bus.vji_rti), 64'd0);
    chk("bp_ir_in", 64'(bus.vji_ir_in), 64'(2'b10));
    finish_a(k, bp_dr, bp_load, 2'b10, 1'b1);

    // Abort mid-SDR with an asynchronous reset.
    snap_a();
    ab_dr   = rand_dr();
    sl_load = rand_dr();
    send_a(2'b11, ab_dr, k);
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (rise_n - b_rise >= 18) hit = 1;
    end
    chk("abort_reached_bit17", 64'(hit), 64'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset_values", obs_rst_a(), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    v = 0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (bus.rsp_valid) v++;
    end
    chk("abort_no_rsp", 64'(v), 64'd0);
    chk("abort_no_udr", 64'(udr_n - b_udr), 64'd0);
    scan_a(2'b01, 38'h3F_FFFF_FFFF, rand_dr(), 2'b00, 1'b1);

    // TCK_DIV=1, 8-bit instance.
    scan_b(8'hC3, 8'h5A);
    scan_b(DWB'($urandom()), DWB'($urandom()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
